// File: rtl/async_uart_pkg.sv
// Shared types and helpers for the byte-wide UART transmitter.
// Holds the frame state encoding, data width and baud divisor calculation.
package async_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Clocks per serial bit, rounded to nearest.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, cleared synchronously.
// Latency: tick is high on the last cycle of each bit period after a clear.
// Backpressure: none; free-running.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/async_uart_tx.sv
// UART transmitter, 8 data bits, LSB first, 1 stop bit; even parity with ASYNC_UART_TX_PARITY_EN.
// Latency: txd drops to start bit the cycle after tx_start is accepted; frame is 10 (11) bit periods.
// Backpressure: tx_start is taken only while ready; requests while busy are dropped, not queued.
module async_uart_tx
    import async_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 ready
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 accept;
    logic                 bit_done;
`ifdef ASYNC_UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    assign accept = (state == IDLE) && tx_start;
    assign ready  = ~tx_busy;

    // Restarting the timer on accept aligns every bit period to the request edge.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .tick(bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef ASYNC_UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift   <= tx_data;
                        state   <= START;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
`ifdef ASYNC_UART_TX_PARITY_EN
                        par_bit <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef ASYNC_UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= par_bit;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            // txd is loaded one bit ahead of the shift so the line stays registered.
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shift[1];
                        end
                    end
                end
`ifdef ASYNC_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_uart_tx.sv
// Directed bench for async_uart_tx at 4 clocks per bit; frame words are built from the byte.
// Parity cases run when ASYNC_UART_TX_PARITY_EN is defined.
module tb_async_uart_tx;

    localparam int CPB = 4;
`ifdef ASYNC_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       txd;
    logic       tx_busy;
    logic       ready;

    int n_checks = 0;
    int n_pass   = 0;

    async_uart_tx #(
        .CLK_FREQ(1000000),
        .BAUD    (250000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .txd     (txd),
        .tx_busy (tx_busy),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line bits in transmission order: start, data LSB first, [parity], stop.
    function automatic logic [FB-1:0] frame_word(input logic [7:0] b);
`ifdef ASYNC_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " txd"}, txd, 1'b1);
        check({tag, " busy"}, tx_busy, 1'b0);
        check({tag, " ready"}, ready, 1'b1);
    endtask

    // Call with tx_start already driven high; the accept happens on the next edge.
    task automatic check_frame(input string tag, input logic [7:0] exp_byte, input bit hold,
                               input logic [7:0] next_data, input int poke_k,
                               input logic [7:0] poke_data);
        logic [FB-1:0] fw;
        int slot;
        fw = frame_word(exp_byte);
        for (int k = 1; k <= FRAME_CYC; k++) begin
            step();
            if (k == 1) begin
                tx_data = hold ? next_data : ~exp_byte;
                if (!hold) tx_start = 1'b0;
            end
            if (poke_k > 0 && k == poke_k) begin
                tx_start = 1'b1;
                tx_data  = poke_data;
            end
            if (poke_k > 0 && k == poke_k + 1) tx_start = 1'b0;
            slot = (k - 1) / CPB;
            check($sformatf("%s txd k=%0d", tag, k), txd, fw[slot]);
            check($sformatf("%s busy k=%0d", tag, k), tx_busy, 1'b1);
            check($sformatf("%s ready k=%0d", tag, k), ready, 1'b0);
        end
        step();
        check_idle({tag, " end"});
    endtask

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("reset c%0d", i));
        end
        rst = 1'b0;
        step();
        check_idle("post_reset");

        // Single byte 0x55.
        tx_data  = 8'h55;
        tx_start = 1'b1;
        check_frame("byte55", 8'h55, 1'b0, 8'h00, 0, 8'h00);
        step();
        check_idle("byte55 gap");

        // Start during a frame is dropped; 0xA3 is what goes out.
        tx_data  = 8'hA3;
        tx_start = 1'b1;
        check_frame("ignA3", 8'hA3, 1'b0, 8'h00, 10, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle($sformatf("ignA3 after c%0d", i));
        end

        // Back-to-back with tx_start held: one idle cycle between frames.
        tx_data  = 8'h00;
        tx_start = 1'b1;
        check_frame("b2b00", 8'h00, 1'b1, 8'hFF, 0, 8'h00);
        check_frame("b2bFF", 8'hFF, 1'b0, 8'h00, 0, 8'h00);
        step();
        check_idle("b2b after");

        // Reset at cycle 15 of a 0x00 frame.
        tx_data  = 8'h00;
        tx_start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) tx_start = 1'b0;
            check($sformatf("rstmid busy k=%0d", k), tx_busy, 1'b1);
            check($sformatf("rstmid txd k=%0d", k), txd, 1'b0);
        end
        rst = 1'b1;
        step();
        check_idle("rstmid abort");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle($sformatf("rstmid idle c%0d", i));
        end
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        check_frame("after_rst5A", 8'h5A, 1'b0, 8'h00, 0, 8'h00);

`ifdef ASYNC_UART_TX_PARITY_EN
        step();
        tx_data  = 8'h07;
        tx_start = 1'b1;
        check_frame("par07", 8'h07, 1'b0, 8'h00, 0, 8'h00);
        step();
        tx_data  = 8'h03;
        tx_start = 1'b1;
        check_frame("par03", 8'h03, 1'b0, 8'h00, 0, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
